// File: rtl/imem_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : imem_arb_pkg                                             |
// | Desc    : Shared types, widths and helpers for the imem arbiter.   |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package imem_arb_pkg;

  localparam int AW        = 6;   // imem word-address width (64 words)
  localparam int DW        = 32;  // instruction width
  localparam int MAX_BURST = 8;   // longest debug burst in words
  localparam int CNT_W     = 16;  // conflict counter width
  localparam int LEN_W     = 4;   // burst length field width

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);
  localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    REQ_F = 1'b0,
    REQ_D = 1'b1
  } req_e;

  // Zero-length requests become one beat; oversize requests are clamped.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] res;
    res = len;
    if (len == '0) begin
      res = ONE_LEN;
    end else if (len > MAX_LEN) begin
      res = MAX_LEN;
    end
    return res;
  endfunction

endpackage : imem_arb_pkg
`default_nettype wire

// File: rtl/imem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface : imem_arbiter_if                                        |
// | Desc      : Fetch, debug and imem-port signals of the arbiter.     |
// | Rev       : 1.0  initial release                                   |
// +--------------------------------------------------------------------+
interface imem_arbiter_if
  import imem_arb_pkg::*;
  ();

  // fetch requester
  logic              f_req;
  logic [AW-1:0]     f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DW-1:0]     f_rdata;

  // debug / loader requester
  logic              d_req;
  logic [AW-1:0]     d_addr;
  logic [LEN_W-1:0]  d_len;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DW-1:0]     d_rdata;
  logic              d_done;

  // shared imem read port
  logic [AW-1:0]     imem_a;
  logic [DW-1:0]     imem_rd;

  // observability
  logic [CNT_W-1:0]  conflict_cnt;

  // Arbiter side
  modport slave (
    input  f_req, f_addr, d_req, d_addr, d_len, imem_rd,
    output f_gnt, f_rvalid, f_rdata,
    output d_gnt, d_rvalid, d_rdata, d_done,
    output imem_a, conflict_cnt
  );

  // Requester / memory side
  modport master (
    output f_req, f_addr, d_req, d_addr, d_len, imem_rd,
    input  f_gnt, f_rvalid, f_rdata,
    input  d_gnt, d_rvalid, d_rdata, d_done,
    input  imem_a, conflict_cnt
  );

endinterface : imem_arbiter_if
`default_nettype wire

// File: rtl/imem_rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : imem_rr_arb2                                              |
// | Desc   : Two-input round-robin picker. On a tie the requester that |
// |          did not win last time is granted.                         |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module imem_rr_arb2
  import imem_arb_pkg::*;
(
  input  logic req_f,
  input  logic req_d,
  input  req_e last_winner,
  output logic gnt_f,
  output logic gnt_d,
  output req_e winner
);

  // Pick one requester; winner reflects this cycle's grant or holds history.
  always_comb begin
    gnt_f  = 1'b0;
    gnt_d  = 1'b0;
    winner = last_winner;
    if (req_f && req_d) begin
      if (last_winner == REQ_D) begin
        gnt_f = 1'b1;
      end else begin
        gnt_d = 1'b1;
      end
    end else if (req_f) begin
      gnt_f = 1'b1;
    end else if (req_d) begin
      gnt_d = 1'b1;
    end
    if (gnt_f) begin
      winner = REQ_F;
    end else if (gnt_d) begin
      winner = REQ_D;
    end
  end

endmodule : imem_rr_arb2
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : imem_arbiter                                              |
// | Desc   : Shares the combinational imem read port between the CPU   |
// |          fetch path (single beats) and the debug path (bursts),    |
// |          with registered responses and a saturating conflict count.|
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module imem_arbiter
  import imem_arb_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  imem_arbiter_if.slave   bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  req_e              r_last_winner;
  req_e              w_last_winner_nxt;
  logic [AW-1:0]     r_base;
  logic [AW-1:0]     w_base_nxt;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  w_len_nxt;
  logic [LEN_W-1:0]  r_beat;
  logic [LEN_W-1:0]  w_beat_nxt;

  logic              r_f_rvalid;
  logic [DW-1:0]     r_f_rdata;
  logic              r_d_rvalid;
  logic [DW-1:0]     r_d_rdata;
  logic              r_d_done;
  logic [CNT_W-1:0]  r_conflict_cnt;

  logic              w_f_gnt;
  logic              w_d_gnt;
  logic [AW-1:0]     w_imem_a;
  logic              w_f_issue;
  logic              w_d_issue;
  logic              w_d_last;
  logic              w_conflict;

  logic              w_idle;
  logic              w_arb_gnt_f;
  logic              w_arb_gnt_d;
  req_e              w_arb_winner;
  logic [LEN_W-1:0]  w_req_len;
  logic [AW-1:0]     w_burst_addr;

  assign w_idle       = (r_state == IDLE);
  assign w_req_len    = clamp_len(bus.d_len);
  // Address arithmetic is AW bits wide so bursts wrap from 63 back to 0.
  assign w_burst_addr = r_base + {{(AW-LEN_W){1'b0}}, r_beat};

  // Arbitration only matters in IDLE; BURST requests are simply held off.
  imem_rr_arb2 u_rr_arb (
    .req_f       (bus.f_req & w_idle),
    .req_d       (bus.d_req & w_idle),
    .last_winner (r_last_winner),
    .gnt_f       (w_arb_gnt_f),
    .gnt_d       (w_arb_gnt_d),
    .winner      (w_arb_winner)
  );

  // Next-state, grants, imem address and beat issue decode.
  always_comb begin
    w_state_nxt       = r_state;
    w_last_winner_nxt = r_last_winner;
    w_base_nxt        = r_base;
    w_len_nxt         = r_len;
    w_beat_nxt        = r_beat;
    w_f_gnt           = 1'b0;
    w_d_gnt           = 1'b0;
    w_imem_a          = '0;
    w_f_issue         = 1'b0;
    w_d_issue         = 1'b0;
    w_d_last          = 1'b0;
    w_conflict        = 1'b0;
    // Combinational outputs stay quiet while reset is held.
    if (!reset) begin
      unique case (r_state)
        IDLE: begin
          w_conflict        = bus.f_req && bus.d_req;
          w_last_winner_nxt = w_arb_winner;
          if (w_arb_gnt_f) begin
            w_f_gnt   = 1'b1;
            w_imem_a  = bus.f_addr;
            w_f_issue = 1'b1;
          end else if (w_arb_gnt_d) begin
            w_d_gnt    = 1'b1;
            w_imem_a   = bus.d_addr;
            w_d_issue  = 1'b1;
            w_base_nxt = bus.d_addr;
            w_len_nxt  = w_req_len;
            if (w_req_len == ONE_LEN) begin
              w_d_last   = 1'b1;
              w_beat_nxt = '0;
            end else begin
              w_state_nxt = BURST;
              w_beat_nxt  = ONE_LEN;
            end
          end
        end
        BURST: begin
          w_imem_a  = w_burst_addr;
          w_d_issue = 1'b1;
          if (r_beat == (r_len - ONE_LEN)) begin
            w_d_last    = 1'b1;
            w_beat_nxt  = '0;
            w_state_nxt = IDLE;
          end else begin
            w_beat_nxt = r_beat + ONE_LEN;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // FSM and burst bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_last_winner <= REQ_D;
      r_base        <= '0;
      r_len         <= '0;
      r_beat        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_winner <= w_last_winner_nxt;
      r_base        <= w_base_nxt;
      r_len         <= w_len_nxt;
      r_beat        <= w_beat_nxt;
    end
  end

  // Read responses: data sampled at the issue edge, valid one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_f_rvalid <= 1'b0;
      r_f_rdata  <= '0;
      r_d_rvalid <= 1'b0;
      r_d_rdata  <= '0;
      r_d_done   <= 1'b0;
    end else begin
      r_f_rvalid <= w_f_issue;
      r_d_rvalid <= w_d_issue;
      r_d_done   <= w_d_last;
      if (w_f_issue) begin
        r_f_rdata <= bus.imem_rd;
      end
      if (w_d_issue) begin
        r_d_rdata <= bus.imem_rd;
      end
    end
  end

  // Saturating count of IDLE cycles where both requesters competed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && (r_conflict_cnt != {CNT_W{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
    end
  end

  assign bus.f_gnt        = w_f_gnt;
  assign bus.d_gnt        = w_d_gnt;
  assign bus.imem_a       = w_imem_a;
  assign bus.f_rvalid     = r_f_rvalid;
  assign bus.f_rdata      = r_f_rdata;
  assign bus.d_rvalid     = r_d_rvalid;
  assign bus.d_rdata      = r_d_rdata;
  assign bus.d_done       = r_d_done;
  assign bus.conflict_cnt = r_conflict_cnt;

endmodule : imem_arbiter
`default_nettype wire

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single combinational instruction-memory read port (6-bit word address, 32-bit data) between two requesters.
  - Requester F is the CPU fetch path: single-beat reads.
  - Requester D is the debug/loader path: bursts of 1..MAX_BURST consecutive words.
- Sits between the fetch stage / debug unit and imem.
- Arbitration: round-robin between F and D; registered read responses; saturating conflict counter for observability.

Parameters:
AW, 6, imem word-address width (64 words)
DW, 32, instruction width
MAX_BURST, 8, longest D burst in words; larger requests are clamped to this

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
f_req  in  1  fetch read request; held with f_addr until f_gnt
f_addr  in  AW  fetch word address
f_gnt  out  1  combinational; request accepted this cycle
f_rvalid  out  1  registered; f_rdata valid (1 cycle after f_gnt)
f_rdata  out  DW  registered fetch data
d_req  in  1  debug burst request; held with d_addr/d_len until d_gnt
d_addr  in  AW  burst start address
d_len  in  4  burst length in words (0 treated as 1)
d_gnt  out  1  combinational; burst accepted (single-cycle pulse)
d_rvalid  out  1  registered; one pulse per beat
d_rdata  out  DW  registered beat data
d_done  out  1  registered; coincides with the last beat's d_rvalid
imem_a  out  AW  combinational address to imem
imem_rd  in  DW  combinational data from imem
conflict_cnt  out  16  cycles where F and D requested simultaneously in IDLE; saturates at 0xFFFF

Behaviour:
- Reset (async, active-high) clears all of the following:
  - state = IDLE
  - last_winner = D, so F wins the first conflict
  - f_rvalid, d_rvalid, d_done, rdata registers, beat counter and conflict_cnt all = 0
  - imem_a = 0
- Reset asserted mid-burst aborts the burst. Remaining beats are never delivered, and no d_done is produced.
- FSM states: IDLE, BURST.
- IDLE, each cycle:
  - Only f_req: f_gnt=1, imem_a=f_addr. Next cycle f_rvalid=1 and f_rdata=imem_rd sampled at the grant edge. last_winner=F.
  - Only d_req: d_gnt=1, imem_a=d_addr, beat 0 is issued this cycle.
    - Latch base=d_addr and len=clamp(max(d_len,1), MAX_BURST).
    - If len==1, stay IDLE; else go to BURST with beat=1. last_winner=D.
  - Both requesting: the winner is the requester that is not last_winner. The loser sees gnt=0 and must hold its request. conflict_cnt increments, saturating.
  - Neither requesting: imem_a=0, no grants.
- F throughput in IDLE: 1 read/cycle. Back-to-back f_gnt is allowed and f_rvalid pulses every cycle.
- BURST:
  - Each cycle: imem_a=(base+beat) mod 64, so the address wraps from 63 to 0. d_rvalid fires the following cycle for each beat.
  - f_gnt=0 and d_gnt=0 throughout. Requests arriving during BURST do not increment conflict_cnt.
  - After the beat == len-1 issue, return to IDLE. New arbitration is allowed in that same next cycle.
- d_done=1 in the same cycle as the d_rvalid of beat len-1. A single-beat burst gives d_rvalid and d_done together, one cycle after d_gnt.
- Latency: grant-to-data is exactly 1 cycle for every beat. A burst of len occupies the port for len cycles.
- Only one of f_gnt/d_gnt is ever high, and f_rvalid/d_rvalid are never both high.
- Requests are level-sensitive, with no cancellation. Dropping a request before its grant is legal; it simply withdraws.

Decomposition:
- Package imem_arb_pkg holds:
  - the state enum (IDLE, BURST)
  - the requester enum (REQ_F, REQ_D)
  - localparams AW, DW, MAX_BURST and the 16-bit counter width.
- Sub-module imem_rr_arb2: a 2-input round-robin picker (req_f, req_d, last_winner → grant, winner). It is reusable for other shared ports.
- Response registers and the burst FSM stay in the top module.

Test Plan:
1. Reset sequence: assert reset mid-BURST (d_addr=10, d_len=5, after beat 2) → outputs 0 immediately, no further d_rvalid, no d_done, conflict_cnt=0; the first later conflict is won by F.
2. F only: f_req with f_addr=0..63 back-to-back → f_gnt every cycle; f_rvalid+f_rdata=mem[a] one cycle later; 64 consecutive responses.
3. D wrap burst: d_addr=62, d_len=4 → imem_a sequence 62,63,0,1; four d_rvalid pulses with mem data; d_done on the 4th; f_req held high during the burst gets gnt only in the cycle after the last issue.
4. Clamp and zero-length cases:
   - d_len=15 → exactly 8 beats.
   - d_len=0 → 1 beat, with d_rvalid and d_done asserted together.
5. Conflict alternation: f_req and d_req (d_len=1) both held for 4 cycles → grants F,D,F,D; conflict_cnt=4.
6. Counter saturation: force 70000 conflict cycles → conflict_cnt stops at 0xFFFF.
